// File: rtl/wb8_arbiter.sv
// wb8_arbiter: two-master round-robin arbiter for the 8-bit / 24-bit-address
// Wishbone bus. Grants are held for a whole cyc tenure. A watchdog forces a
// synthetic acknowledge on stalled strobes so a hung slave cannot lock a master.

// Per-master response path: ack and read data back to one master.
module wb8_arb_resp #(
   parameter logic [7:0] TMO_DATA = 8'hFF
) (
   input  logic       gnt,
   input  logic [7:0] s_dat,
   input  logic       s_ack,
   input  logic       tmo_fire,
   output logic       ack,
   output logic [7:0] dat
);

   // Only the granted master sees the slave; a forced ack substitutes TMO_DATA.
   always_comb begin
      ack = 1'b0;
      dat = '0;
      if (gnt) begin
         ack = s_ack | tmo_fire;
         dat = tmo_fire ? TMO_DATA : s_dat;
      end
   end

endmodule

module wb8_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter logic [7:0]  TMO_DATA       = 8'hFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [23:0] m0_adr_i,
   input  logic [7:0]  m0_dat_i,
   output logic [7:0]  m0_dat_o,
   input  logic        m0_we_i,
   input  logic        m0_sel_i,
   input  logic        m0_stb_i,
   input  logic        m0_cyc_i,
   output logic        m0_ack_o,
   input  logic [23:0] m1_adr_i,
   input  logic [7:0]  m1_dat_i,
   output logic [7:0]  m1_dat_o,
   input  logic        m1_we_i,
   input  logic        m1_sel_i,
   input  logic        m1_stb_i,
   input  logic        m1_cyc_i,
   output logic        m1_ack_o,
   output logic [23:0] s_adr_o,
   output logic [7:0]  s_dat_o,
   input  logic [7:0]  s_dat_i,
   output logic        s_we_o,
   output logic        s_sel_o,
   output logic        s_stb_o,
   output logic        s_cyc_o,
   input  logic        s_ack_i,
   output logic        timeout_o,
   input  logic        timeout_clr_i,
   output logic        timeout_master_o
);

   localparam int NUM_M = 2;
   localparam int CW    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] TMO_LIM = CW'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } state_t;

   state_t state, state_nxt;
   logic   last, last_nxt;

   // Master request buses packed so the slave mux is a plain index.
   logic [NUM_M-1:0][23:0] m_adr;
   logic [NUM_M-1:0][7:0]  m_wdat;
   logic [NUM_M-1:0]       m_we;
   logic [NUM_M-1:0]       m_sel;
   logic [NUM_M-1:0]       m_stb;
   logic [NUM_M-1:0]       m_cyc;
   logic [NUM_M-1:0]       m_ack;
   logic [NUM_M-1:0][7:0]  m_rdat;
   logic [NUM_M-1:0]       gnt_vec;

   logic          granted;
   logic          gnt_idx;
   logic          gnt_stb;
   logic [CW-1:0] cnt;
   logic          tmo_fire;

   assign m_adr  = {m1_adr_i, m0_adr_i};
   assign m_wdat = {m1_dat_i, m0_dat_i};
   assign m_we   = {m1_we_i,  m0_we_i};
   assign m_sel  = {m1_sel_i, m0_sel_i};
   assign m_stb  = {m1_stb_i, m0_stb_i};
   assign m_cyc  = {m1_cyc_i, m0_cyc_i};

   assign gnt_vec = {state == GNT1, state == GNT0};
   assign granted = |gnt_vec;
   assign gnt_idx = gnt_vec[1];
   assign gnt_stb = granted & m_stb[gnt_idx];

   // Watchdog fires for one cycle when a strobe has stalled for the full limit;
   // a slave ack arriving in that same cycle takes priority.
   assign tmo_fire = gnt_stb & (cnt == TMO_LIM) & ~s_ack_i;

   // State and round-robin history register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         last  <= 1'b1;
      end else begin
         state <= state_nxt;
         last  <= last_nxt;
      end
   end

   // Next-state: grant from IDLE only, hold the grant until that master drops cyc.
   always_comb begin
      state_nxt = state;
      last_nxt  = last;
      case (state)
         IDLE: begin
            if (m_cyc[0] && m_cyc[1]) begin
               state_nxt = last ? GNT0 : GNT1;
               last_nxt  = ~last;
            end else if (m_cyc[0]) begin
               state_nxt = GNT0;
               last_nxt  = 1'b0;
            end else if (m_cyc[1]) begin
               state_nxt = GNT1;
               last_nxt  = 1'b1;
            end
         end
         GNT0: if (!m_cyc[0]) state_nxt = IDLE;
         GNT1: if (!m_cyc[1]) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Slave request mux: combinational pass-through from the granted master.
   always_comb begin
      s_adr_o = '0;
      s_dat_o = '0;
      s_we_o  = 1'b0;
      s_sel_o = 1'b0;
      s_stb_o = 1'b0;
      s_cyc_o = 1'b0;
      if (granted) begin
         s_adr_o = m_adr[gnt_idx];
         s_dat_o = m_wdat[gnt_idx];
         s_we_o  = m_we[gnt_idx];
         s_sel_o = m_sel[gnt_idx];
         s_stb_o = m_stb[gnt_idx] & ~tmo_fire;
         s_cyc_o = m_cyc[gnt_idx];
      end
   end

   // Stall counter: counts consecutive unacked strobe cycles of the owner.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (!gnt_stb || s_ack_i || tmo_fire) begin
         cnt <= '0;
      end else if (cnt != '1) begin
         cnt <= cnt + CW'(1);
      end
   end

   // Sticky timeout flag; a forced ack beats a simultaneous clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         timeout_o        <= 1'b0;
         timeout_master_o <= 1'b0;
      end else if (tmo_fire) begin
         timeout_o        <= 1'b1;
         timeout_master_o <= gnt_idx;
      end else if (timeout_clr_i) begin
         timeout_o        <= 1'b0;
      end
   end

   for (genvar i = 0; i < NUM_M; i++) begin : g_resp
      wb8_arb_resp #(
         .TMO_DATA (TMO_DATA)
      ) u_resp (
         .gnt      (gnt_vec[i]),
         .s_dat    (s_dat_i),
         .s_ack    (s_ack_i),
         .tmo_fire (tmo_fire),
         .ack      (m_ack[i]),
         .dat      (m_rdat[i])
      );
   end

   assign m0_ack_o = m_ack[0];
   assign m1_ack_o = m_ack[1];
   assign m0_dat_o = m_rdat[0];
   assign m1_dat_o = m_rdat[1];

endmodule
